multi_timer: RTL and testbench

- N-channel programmable tick generator; successor to the single fixed-period tick timer.
- Each channel has:
  - a runtime-loadable period;
  - a periodic or one-shot mode;
  - an immediate or after-delay first tick;
  - double-buffered (shadow) configuration.
- Sits beside control FSMs and peripheral blocks that need several independent strobes from one clock domain.

---
 rtl/multi_timer_pkg.sv | 23 ++
 rtl/timer_channel.sv | 104 ++++++++++
 rtl/multi_timer.sv | 76 +++++++
 tb/tb_multi_timer.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_timer_pkg.sv
// rtl/multi_timer_pkg.sv - shared state, config types and width helper for multi_timer
package multi_timer_pkg;

  // Config period is carried at the widest supported width; channels use CNT_W of it.
  localparam int PERIOD_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [PERIOD_MAX_W-1:0] period;
    logic                    oneshot;
    logic                    after_delay;
  } cfg_t;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one timer channel: shadow/active config, counter, IDLE/RUN/DONE FSM
module timer_channel
  import multi_timer_pkg::*;
#(
  parameter int CNT_W           = 16,
  parameter int RST_PERIOD      = 1000,
  parameter bit RST_ONESHOT     = 1'b0,
  parameter bit RST_AFTER_DELAY = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic step,
  input  logic cfg_we,
  input  cfg_t cfg,
  output logic tick,
  output logic done
);

  localparam cfg_t RST_CFG = '{
    period:      PERIOD_MAX_W'(RST_PERIOD),
    oneshot:     RST_ONESHOT,
    after_delay: RST_AFTER_DELAY
  };

  state_t           state;
  cfg_t             shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] act_period;
  logic             act_oneshot;

  // after_delay only matters at IDLE->RUN entry, where it is read from the shadow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      shadow      <= RST_CFG;
      cnt         <= '0;
      act_period  <= CNT_W'(RST_PERIOD);
      act_oneshot <= RST_ONESHOT;
      tick        <= 1'b0;
      done        <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (cfg_we) begin
        shadow <= cfg;
      end
      if (!en) begin
        state <= ST_IDLE;
        cnt   <= '0;
        done  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            cnt <= '0;
            if (shadow.period != '0) begin
              act_period  <= shadow.period[CNT_W-1:0];
              act_oneshot <= shadow.oneshot;
              if (!shadow.after_delay) begin
                tick <= 1'b1;
                if (shadow.oneshot) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else begin
                  state <= ST_RUN;
                end
              end else begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (step) begin
              if (cnt == act_period - 1'b1) begin
                cnt         <= '0;
                tick        <= 1'b1;
                act_period  <= shadow.period[CNT_W-1:0];
                act_oneshot <= shadow.oneshot;
                if (act_oneshot) begin
                  state <= ST_DONE;
                  done  <= 1'b1;
                end else if (shadow.period == '0) begin
                  // A zero period reloaded at wrap parks the channel like P=0 at entry.
                  state <= ST_IDLE;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          ST_DONE: begin
            cnt  <= '0;
            done <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            cnt   <= '0;
            done  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N-channel programmable tick generator, config select decode and prescaler
// Optional shared prescaler enabled by MULTI_TIMER_PRESCALE_EN.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int CNT_W           = 16,
  parameter int RST_PERIOD      = 1000,
  parameter bit RST_ONESHOT     = 1'b0,
  parameter bit RST_AFTER_DELAY = 1'b0,
  parameter int PRESC_DIV       = 10
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_CH-1:0]             en,
  input  logic                        cfg_we,
  input  logic [sel_width(N_CH)-1:0]  cfg_sel,
  input  logic [CNT_W-1:0]            cfg_period,
  input  logic                        cfg_oneshot,
  input  logic                        cfg_after_delay,
  output logic [N_CH-1:0]             tick,
  output logic [N_CH-1:0]             done
);

  localparam int SEL_W = sel_width(N_CH);

  cfg_t cfg_in;
  logic step;

  assign cfg_in = '{
    period:      PERIOD_MAX_W'(cfg_period),
    oneshot:     cfg_oneshot,
    after_delay: cfg_after_delay
  };

`ifdef MULTI_TIMER_PRESCALE_EN
  localparam int PW = sel_width(PRESC_DIV);

  logic [PW-1:0] presc;

  // Free-running; never restarted by channel enables so all channels share one phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (presc == PW'(PRESC_DIV - 1)) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  assign step = (presc == PW'(PRESC_DIV - 1));
`else
  assign step = 1'b1;
`endif

  // Selects at or beyond N_CH match no channel, so such writes are dropped.
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(
      .CNT_W           (CNT_W),
      .RST_PERIOD      (RST_PERIOD),
      .RST_ONESHOT     (RST_ONESHOT),
      .RST_AFTER_DELAY (RST_AFTER_DELAY)
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (en[i]),
      .step    (step),
      .cfg_we  (cfg_we && (cfg_sel == SEL_W'(i))),
      .cfg     (cfg_in),
      .tick    (tick[i]),
      .done    (done[i])
    );
  end

endmodule

// File: tb/tb_multi_timer.sv
// tb/tb_multi_timer.sv - directed self-checking bench for multi_timer
module tb_multi_timer;

  localparam int NC = 3;

  logic          clk;
  logic          reset_n;
  logic [NC-1:0] en;
  logic          cfg_we;
  logic [1:0]    cfg_sel;
  logic [15:0]   cfg_period;
  logic          cfg_oneshot;
  logic          cfg_after_delay;
  logic [NC-1:0] tick;
  logic [NC-1:0] done;

  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;
  int k;
  int tq[NC][$];
  int done_first[NC];
  int eq[$];

  multi_timer #(
    .N_CH            (NC),
    .CNT_W           (16),
    .RST_PERIOD      (1000),
    .RST_ONESHOT     (1'b0),
    .RST_AFTER_DELAY (1'b0),
    .PRESC_DIV       (10)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .en              (en),
    .cfg_we          (cfg_we),
    .cfg_sel         (cfg_sel),
    .cfg_period      (cfg_period),
    .cfg_oneshot     (cfg_oneshot),
    .cfg_after_delay (cfg_after_delay),
    .tick            (tick),
    .done            (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_no++;

  // Tick observed at this negedge was launched by posedge number cyc_no.
  always @(negedge clk) begin
    for (int c = 0; c < NC; c++) begin
      if (tick[c]) tq[c].push_back(cyc_no);
      if (done[c] && done_first[c] < 0) done_first[c] = cyc_no;
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int c = 0; c < NC; c++) begin
      tq[c].delete();
      done_first[c] = -1;
    end
  endtask

  task automatic wr_cfg(input int sel, input int p, input bit os, input bit ad);
    cfg_we          = 1'b1;
    cfg_sel         = 2'(sel);
    cfg_period      = 16'(p);
    cfg_oneshot     = os;
    cfg_after_delay = ad;
    cyc(1);
    cfg_we          = 1'b0;
  endtask

  task automatic chk_ticks(input string tag, input int c);
    check({tag, "_count"}, tq[c].size(), eq.size());
    for (int i = 0; i < eq.size(); i++) begin
      check($sformatf("%s_t%0d", tag, i), (i < tq[c].size()) ? tq[c][i] : -1, eq[i]);
    end
  endtask

  initial begin
    reset_n = 1'b0; en = '0; cfg_we = 1'b0; cfg_sel = '0;
    cfg_period = '0; cfg_oneshot = 1'b0; cfg_after_delay = 1'b0;
    clr();
    cyc(3);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;
    cyc(1);
    clr();

    // ch0 P=5 periodic, immediate first tick
    wr_cfg(0, 5, 1'b0, 1'b0);
    en[0] = 1'b1; k = cyc_no + 1;
    cyc(13);
    eq = {k, k + 5, k + 10};
    chk_ticks("p5", 0);
    check("p5_done", done_first[0], -1);
    en[0] = 1'b0; cyc(1); clr();

    // ch1 P=3 one-shot after delay
    wr_cfg(1, 3, 1'b1, 1'b1);
    en[1] = 1'b1; k = cyc_no + 1;
    cyc(8);
    eq = {k + 3};
    chk_ticks("os", 1);
    check("os_done_at", done_first[1], k + 3);
    check("os_done_lvl", done[1], 1);
    en[1] = 1'b0; cyc(1);
    check("os_done_clr", done[1], 0);
    clr();

    // ch2 P=4, mid-period write of P=2
    wr_cfg(2, 4, 1'b0, 1'b0);
    en[2] = 1'b1; k = cyc_no + 1;
    cyc(2);
    wr_cfg(2, 2, 1'b0, 1'b0);
    cyc(10);
    eq = {k, k + 4, k + 6, k + 8, k + 10};
    chk_ticks("mid", 2);
    en[2] = 1'b0; cyc(1); clr();

    // ch2 P=4, write of P=2 landing exactly on a wrap edge
    wr_cfg(2, 4, 1'b0, 1'b0);
    en[2] = 1'b1; k = cyc_no + 1;
    cyc(4);
    wr_cfg(2, 2, 1'b0, 1'b0);
    cyc(10);
    eq = {k, k + 4, k + 8, k + 10, k + 12};
    chk_ticks("wrap", 2);
    en[2] = 1'b0; cyc(1); clr();

    // P=1 ticks every cycle
    wr_cfg(0, 1, 1'b0, 1'b0);
    en[0] = 1'b1; k = cyc_no + 1;
    cyc(6);
    eq = {k, k + 1, k + 2, k + 3, k + 4};
    chk_ticks("p1", 0);
    en[0] = 1'b0; cyc(1); clr();

    // P=0 never ticks
    wr_cfg(1, 0, 1'b0, 1'b0);
    en[1] = 1'b1;
    cyc(10);
    check("p0_count", tq[1].size(), 0);
    check("p0_done", done_first[1], -1);
    en[1] = 1'b0; cyc(1); clr();

    // out-of-range select ignored; en[0] dropped just before its second tick
    wr_cfg(0, 6, 1'b0, 1'b1);
    wr_cfg(1, 6, 1'b0, 1'b1);
    wr_cfg(2, 6, 1'b0, 1'b1);
    wr_cfg(3, 2, 1'b0, 1'b0);
    en = 3'b111; k = cyc_no + 1;
    cyc(11);
    en[0] = 1'b0;
    cyc(4);
    eq = {k + 6};
    chk_ticks("sel_ch0", 0);
    eq = {k + 6, k + 12};
    chk_ticks("sel_ch1", 1);
    chk_ticks("sel_ch2", 2);
    en = '0; cyc(1); clr();

    // async reset between edges while ticking / done
    wr_cfg(0, 4, 1'b0, 1'b0);
    wr_cfg(1, 2, 1'b1, 1'b0);
    en = 3'b011;
    cyc(1);
    check("ar_pre_tick", tick[0], 1);
    check("ar_pre_done", done[1], 1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_tick", tick, 0);
    check("ar_done", done, 0);
    en = '0;
    cyc(2);
    reset_n = 1'b1;
    cyc(1); clr();

    // reset config: default P=1000 immediate periodic on every channel
    en = 3'b111; k = cyc_no + 1;
    cyc(1002);
    eq = {k, k + 1000};
    chk_ticks("def_ch0", 0);
    chk_ticks("def_ch1", 1);
    chk_ticks("def_ch2", 2);
    check("def_done", done, 0);
    en = '0; cyc(1); clr();

`ifdef MULTI_TIMER_PRESCALE_EN
    wr_cfg(0, 3, 1'b0, 1'b1);
    en[0] = 1'b1;
    cyc(75);
    check("ps_count_ge2", tq[0].size() >= 2, 1);
    if (tq[0].size() >= 2) check("ps_spacing", tq[0][1] - tq[0][0], 30);
    en = '0; cyc(1); clr();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
